// File: rtl/exec_pkg.sv
// Shared encodings for the execute/memory stage: opcodes, ALU operations,
// immediate-format and next-PC selects, and the decoded control bundle.
package exec_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_IALU  = 6'h01;
  localparam logic [5:0] OP_LOAD  = 6'h02;
  localparam logic [5:0] OP_STORE = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_JAL   = 6'h06;
  localparam logic [5:0] OP_JALR  = 6'h07;
  localparam logic [5:0] OP_LUI   = 6'h08;
  localparam logic [5:0] OP_EXIT  = 6'h3F;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'h0,
    ALU_SUB  = 4'h1,
    ALU_AND  = 4'h2,
    ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4,
    ALU_SLL  = 4'h5,
    ALU_SRL  = 4'h6,
    ALU_SRA  = 4'h7,
    ALU_SLT  = 4'h8,
    ALU_SLTU = 4'h9,
    ALU_MUL  = 4'hA,
    ALU_PASS = 4'hB
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4
  } imm_src_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JREG   = 2'b10
  } pc_src_e;

  // Branch flags are resolved against eq after decode, so pc_src here only
  // carries the unconditional jump targets.
  typedef struct packed {
    alu_op_e  alu_op;
    logic     alu_src;
    imm_src_e imm_src;
    logic     result_src;
    logic     reg_write;
    logic     mem_write;
    logic     wd3_src;
    logic     is_exit;
    logic     is_beq;
    logic     is_bne;
    pc_src_e  pc_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_op:     ALU_ADD,
    alu_src:    1'b0,
    imm_src:    IMM_I,
    result_src: 1'b0,
    reg_write:  1'b0,
    mem_write:  1'b0,
    wd3_src:    1'b0,
    is_exit:    1'b0,
    is_beq:     1'b0,
    is_bne:     1'b0,
    pc_src:     PC_PLUS4
  };

endpackage

// File: rtl/exec_alu.sv
// 32-bit ALU with operand-equality flag; unused op codes yield zero.
module exec_alu
  import exec_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_e     i_op,
  output logic [31:0] o_y,
  output logic        o_eq
);

  logic [4:0] w_shamt;

  assign w_shamt = i_b[4:0];
  assign o_eq    = (i_a == i_b);

  // NOTE: o_y gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    o_y = '0;
    case (i_op)
      ALU_ADD:  o_y = i_a + i_b;
      ALU_SUB:  o_y = i_a - i_b;
      ALU_AND:  o_y = i_a & i_b;
      ALU_OR:   o_y = i_a | i_b;
      ALU_XOR:  o_y = i_a ^ i_b;
      ALU_SLL:  o_y = i_a << w_shamt;
      ALU_SRL:  o_y = i_a >> w_shamt;
      ALU_SRA:  o_y = $signed(i_a) >>> w_shamt;
      ALU_SLT:  o_y = {31'b0, $signed(i_a) < $signed(i_b)};
      ALU_SLTU: o_y = {31'b0, i_a < i_b};
      ALU_MUL:  o_y = i_a * i_b;
      ALU_PASS: o_y = i_b;
      default:  o_y = '0;
    endcase
  end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory stage: decode, ALU, word-addressed data memory, sticky halt.
// Define EXEC_TRACE_EN to print a per-cycle trace of the datapath.
module exec_mem_unit
  import exec_pkg::*;
#(
  parameter int DMEM_AW = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic [31:0] imm_op,
  output logic [31:0] result,
  output logic [31:0] alu_out,
  output logic        eq,
  output logic [2:0]  imm_src,
  output logic [1:0]  pc_src,
  output logic        reg_write,
  output logic        wd3_src,
  output logic        exit,
  output logic        halted
);

  localparam int WORDS = 2 ** (DMEM_AW - 2);

  ctrl_t                w_dec;
  pc_src_e              w_pc_src;
  logic [31:0]          w_op2;
  logic [31:0]          w_rdata;
  logic [DMEM_AW-3:0]   w_word_addr;
  logic                 w_eq;
  logic                 w_mem_we;
  logic                 w_unused;
  logic                 r_halted;
  logic [31:0]          r_mem [WORDS];

  always_comb begin
    w_dec = CTRL_NOP;
    case (instr[31:26])
      OP_RTYPE: begin
        w_dec.alu_op    = alu_op_e'(instr[13:10]);
        w_dec.reg_write = 1'b1;
      end
      OP_IALU: begin
        w_dec.alu_op    = alu_op_e'(instr[13:10]);
        w_dec.alu_src   = 1'b1;
        w_dec.reg_write = 1'b1;
      end
      OP_LOAD: begin
        w_dec.alu_src    = 1'b1;
        w_dec.result_src = 1'b1;
        w_dec.reg_write  = 1'b1;
      end
      OP_STORE: begin
        w_dec.alu_src   = 1'b1;
        w_dec.imm_src   = IMM_S;
        w_dec.mem_write = 1'b1;
      end
      OP_BEQ: begin
        w_dec.alu_op  = ALU_SUB;
        w_dec.imm_src = IMM_B;
        w_dec.is_beq  = 1'b1;
      end
      OP_BNE: begin
        w_dec.alu_op  = ALU_SUB;
        w_dec.imm_src = IMM_B;
        w_dec.is_bne  = 1'b1;
      end
      OP_JAL: begin
        w_dec.imm_src   = IMM_J;
        w_dec.pc_src    = PC_BRANCH;
        w_dec.reg_write = 1'b1;
        w_dec.wd3_src   = 1'b1;
      end
      OP_JALR: begin
        w_dec.alu_src   = 1'b1;
        w_dec.pc_src    = PC_JREG;
        w_dec.reg_write = 1'b1;
        w_dec.wd3_src   = 1'b1;
      end
      OP_LUI: begin
        w_dec.alu_op    = ALU_PASS;
        w_dec.alu_src   = 1'b1;
        w_dec.imm_src   = IMM_U;
        w_dec.reg_write = 1'b1;
      end
      OP_EXIT: w_dec.is_exit = 1'b1;
      default: w_dec = CTRL_NOP;
    endcase
  end

  assign w_op2 = w_dec.alu_src ? imm_op : rd2;

  exec_alu u_alu (
    .i_a  (rd1),
    .i_b  (w_op2),
    .i_op (w_dec.alu_op),
    .o_y  (alu_out),
    .o_eq (w_eq)
  );

  // A halted core must not redirect the PC, so halt overrides taken branches.
  always_comb begin
    w_pc_src = w_dec.pc_src;
    if ((w_dec.is_beq && w_eq) || (w_dec.is_bne && !w_eq)) w_pc_src = PC_BRANCH;
    if (r_halted) w_pc_src = PC_PLUS4;
  end

  assign w_mem_we    = w_dec.mem_write & ~r_halted;
  assign w_word_addr = alu_out[DMEM_AW-1:2];
  assign w_rdata     = r_mem[w_word_addr];
  assign w_unused    = ^{instr[25:14], instr[9:0], alu_out[1:0], alu_out[31:DMEM_AW]};

  assign result    = w_dec.result_src ? w_rdata : alu_out;
  assign eq        = w_eq;
  assign imm_src   = w_dec.imm_src;
  assign pc_src    = w_pc_src;
  assign reg_write = w_dec.reg_write & ~r_halted;
  assign wd3_src   = w_dec.wd3_src;
  assign exit      = w_dec.is_exit;
  assign halted    = r_halted;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst)                r_halted <= 1'b0;
    else if (w_dec.is_exit)  r_halted <= 1'b1;
  end

  // NOTE: the memory array is deliberately not reset; contents survive rst and
  // only writes are suppressed, which also keeps it mappable to RAM macros.
  always_ff @(posedge clk) begin
    if (rst && w_mem_we) r_mem[w_word_addr] <= rd2;
  end

`ifdef EXEC_TRACE_EN
  always_ff @(posedge clk) begin
    if (rst)
      $display("trace: instr=%h a=%h b=%h alu_out=%h result=%h reg_write=%b mem_write=%b",
               instr, rd1, w_op2, alu_out, result, reg_write, w_mem_we);
  end
`endif

endmodule

// File: tb/tb_exec_mem_unit.sv
// Directed self-checking bench for exec_mem_unit with hand-computed expectations.
module tb_exec_mem_unit;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr, rd1, rd2, imm_op;
  logic [31:0] result, alu_out;
  logic        eq, reg_write, wd3_src, exit, halted;
  logic [2:0]  imm_src;
  logic [1:0]  pc_src;

  int checks   = 0;
  int failures = 0;

  exec_mem_unit #(.DMEM_AW(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .instr     (instr),
    .rd1       (rd1),
    .rd2       (rd2),
    .imm_op    (imm_op),
    .result    (result),
    .alu_out   (alu_out),
    .eq        (eq),
    .imm_src   (imm_src),
    .pc_src    (pc_src),
    .reg_write (reg_write),
    .wd3_src   (wd3_src),
    .exit      (exit),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [3:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    instr  = {op, 12'h0, fn, 10'h0};
    rd1    = a;
    rd2    = b;
    imm_op = imm;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(OP_RTYPE, 4'h0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    check("reset_halted", 32'(halted), 32'd0);
    rst = 1'b1;

    drive(OP_RTYPE, 4'h0, 32'd5, 32'd7, 32'h0);
    check("add_alu_out", alu_out, 32'd12);
    check("add_result", result, 32'd12);
    check("add_reg_write", 32'(reg_write), 32'd1);
    check("add_pc_src", 32'(pc_src), 32'd0);

    drive(OP_RTYPE, 4'h1, 32'd5, 32'd7, 32'h0);
    check("sub_alu_out", alu_out, 32'hFFFF_FFFE);

    drive(OP_STORE, 4'h0, 32'h100, 32'hDEAD_BEEF, 32'd4);
    check("store_addr", alu_out, 32'h104);
    check("store_reg_write", 32'(reg_write), 32'd0);
    check("store_imm_src", 32'(imm_src), 32'd1);
    tick();

    drive(OP_LOAD, 4'h0, 32'h100, 32'h0, 32'd4);
    check("load_result", result, 32'hDEAD_BEEF);
    check("load_reg_write", 32'(reg_write), 32'd1);
    check("load_imm_src", 32'(imm_src), 32'd0);

    drive(OP_LOAD, 4'h0, 32'h1100, 32'h0, 32'd6);
    check("load_wrap_result", result, 32'hDEAD_BEEF);

    drive(OP_BEQ, 4'h0, 32'd3, 32'd3, 32'h40);
    check("beq_eq", 32'(eq), 32'd1);
    check("beq_taken_pc", 32'(pc_src), 32'd1);
    check("beq_imm_src", 32'(imm_src), 32'd2);
    drive(OP_BEQ, 4'h0, 32'd3, 32'd4, 32'h40);
    check("beq_ne_eq", 32'(eq), 32'd0);
    check("beq_not_taken_pc", 32'(pc_src), 32'd0);
    drive(OP_BNE, 4'h0, 32'd3, 32'd4, 32'h40);
    check("bne_taken_pc", 32'(pc_src), 32'd1);
    drive(OP_BNE, 4'h0, 32'd3, 32'd3, 32'h40);
    check("bne_not_taken_pc", 32'(pc_src), 32'd0);

    drive(OP_JALR, 4'h0, 32'h200, 32'h0, 32'd8);
    check("jalr_result", result, 32'h208);
    check("jalr_pc_src", 32'(pc_src), 32'd2);
    check("jalr_wd3_src", 32'(wd3_src), 32'd1);
    check("jalr_reg_write", 32'(reg_write), 32'd1);

    drive(OP_JAL, 4'h0, 32'h0, 32'h0, 32'h10);
    check("jal_pc_src", 32'(pc_src), 32'd1);
    check("jal_imm_src", 32'(imm_src), 32'd3);
    check("jal_wd3_src", 32'(wd3_src), 32'd1);

    drive(OP_LUI, 4'h0, 32'hFFFF, 32'h0, 32'h1234_5000);
    check("lui_result", result, 32'h1234_5000);
    check("lui_imm_src", 32'(imm_src), 32'd4);

    drive(OP_IALU, 4'h7, 32'h8000_0000, 32'h0, 32'd4);
    check("sra_result", alu_out, 32'hF800_0000);
    drive(OP_RTYPE, 4'h9, 32'd1, 32'hFFFF_FFFF, 32'h0);
    check("sltu_result", alu_out, 32'd1);
    drive(OP_RTYPE, 4'h8, 32'd1, 32'hFFFF_FFFF, 32'h0);
    check("slt_result", alu_out, 32'd0);
    drive(OP_RTYPE, 4'hA, 32'h1_0000, 32'h1_0001, 32'h0);
    check("mul_low", alu_out, 32'h0001_0000);
    drive(OP_RTYPE, 4'hC, 32'd5, 32'd7, 32'h0);
    check("op_c_zero", alu_out, 32'd0);

    drive(6'h20, 4'h3, 32'd2, 32'd3, 32'h99);
    check("nop_reg_write", 32'(reg_write), 32'd0);
    check("nop_pc_src", 32'(pc_src), 32'd0);
    check("nop_imm_src", 32'(imm_src), 32'd0);
    check("nop_wd3_src", 32'(wd3_src), 32'd0);
    check("nop_exit", 32'(exit), 32'd0);
    check("nop_alu_add", alu_out, 32'd5);

    drive(OP_EXIT, 4'h0, 32'h0, 32'h0, 32'h0);
    check("exit_comb", 32'(exit), 32'd1);
    check("exit_not_yet_halted", 32'(halted), 32'd0);
    tick();
    check("halted_set", 32'(halted), 32'd1);

    drive(OP_STORE, 4'h0, 32'h100, 32'h5555_5555, 32'd4);
    check("halted_store_reg_write", 32'(reg_write), 32'd0);
    check("halted_store_pc_src", 32'(pc_src), 32'd0);
    tick();
    check("halted_sticky", 32'(halted), 32'd1);
    drive(OP_LOAD, 4'h0, 32'h100, 32'h0, 32'd4);
    check("halted_mem_unchanged", result, 32'hDEAD_BEEF);
    check("halted_load_reg_write", 32'(reg_write), 32'd0);
    drive(OP_BEQ, 4'h0, 32'd3, 32'd3, 32'h40);
    check("halted_beq_pc_src", 32'(pc_src), 32'd0);

    rst = 1'b0;
    drive(OP_STORE, 4'h0, 32'h100, 32'h5555_5555, 32'd4);
    tick();
    check("reset_clears_halted", 32'(halted), 32'd0);
    rst = 1'b1;
    drive(OP_LOAD, 4'h0, 32'h100, 32'h0, 32'd4);
    check("reset_mem_retained", result, 32'hDEAD_BEEF);
    check("post_reset_reg_write", 32'(reg_write), 32'd1);

    drive(OP_STORE, 4'h0, 32'h108, 32'hCAFE_F00D, 32'd0);
    tick();
    drive(OP_LOAD, 4'h0, 32'h104, 32'h0, 32'd4);
    check("post_reset_store_load", result, 32'hCAFE_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_mem_unit.md
EXEC_MEM_UNIT -- requirements
Module: exec_mem_unit

Interface
REQ-001 Parameter DMEM_AW, default 12, byte-address width of data memory (2^DMEM_AW bytes).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-low.
REQ-004 instr  in  32  current instruction; opcode [31:26], imm/funct fields decoded here, register fields [4:0]/[9:5]/[18:14] used externally.
REQ-005 rd1  in  32  ALU operand 1 (register rs1).
REQ-006 rd2  in  32  register rs2; ALU operand 2 when alu_src=0, store data always.
REQ-007 imm_op  in  32  sign-extended immediate produced externally per imm_src.
REQ-008 result  out  32  write-back value: read data if result_src=1, else ALU output.
REQ-009 alu_out  out  32  ALU result (also data memory address).
REQ-010 eq  out  1  1 when ALU operand 1 equals ALU operand 2.
REQ-011 imm_src  out  3  immediate format select to external extender.
REQ-012 pc_src  out  2  00 PC+4, 01 PC+imm_op, 10 result (jump-register), 11 unused.
REQ-013 reg_write  out  1  register-file write enable.
REQ-014 wd3_src  out  1  1 selects PC+4 as register write data (link).
REQ-015 exit  out  1  combinational: current instruction is EXIT.
REQ-016 halted  out  1  registered sticky halt flag.

Function
REQ-017 ALU op codes (4 bit): 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, A MUL (low 32 bits), B PASS operand 2, C-F yield 0; shifts use operand2[4:0]; SLT/SLTU yield 0/1; arithmetic wraps modulo 2^32.
REQ-018 ALU operand 2 = imm_op when alu_src=1, else rd2; eq compares these two operands.
REQ-019 Decode (opcode -> controls; unlisted controls 0): 00 R-type: alu op=instr[13:10], reg_write=1; 01 I-ALU: alu op=instr[13:10], alu_src=1, imm_src=0, reg_write=1; 02 LOAD: ADD, alu_src=1, imm_src=0, result_src=1, reg_write=1; 03 STORE: ADD, alu_src=1, imm_src=1, mem write=1; 04 BEQ: SUB, imm_src=2, pc_src=01 iff eq; 05 BNE: SUB, imm_src=2, pc_src=01 iff !eq; 06 JAL: imm_src=3, pc_src=01, reg_write=1, wd3_src=1; 07 JALR: ADD, alu_src=1, imm_src=0, pc_src=10, reg_write=1, wd3_src=1; 08 LUI: PASS, alu_src=1, imm_src=4, reg_write=1; 3F EXIT: exit=1.
REQ-020 Any other opcode is a NOP: all controls 0, alu op ADD.
REQ-021 Data memory byte-addressed, little-endian, 32-bit word access at alu_out[DMEM_AW-1:2]; upper address bits and alu_out[1:0] ignored (aligned, wraps).
REQ-022 Memory read combinational (zero latency); write takes effect on the rising edge where mem write=1, rst=1, halted=0; read of same word in that cycle returns old data.
REQ-023 halted sets on the rising edge where exit=1 and rst=1; stays set until reset.
REQ-024 While halted=1: reg_write=0, mem write=0, pc_src=00 regardless of instr.

Reset
REQ-025 On rising edge with rst=0: halted<=0; memory writes suppressed; memory contents retained (not cleared).
REQ-026 All other outputs are combinational from inputs and halted; after reset they reflect decode of instr.

Configuration
REQ-027 Macro EXEC_TRACE_EN: when defined, each rising edge with rst=1 prints instr, alu operands, alu_out, result, reg_write, mem write; when undefined, no simulation output and identical logic.

Structure
REQ-028 Package exec_pkg holds opcode constants, ALU op enum, imm_src and pc_src encodings.
REQ-029 One sub-module exec_alu (operands, op -> result, eq); decode, memory, result mux in the top.

Verification
REQ-030 R-type ADD, funct=0, rd1=5, rd2=7 -> alu_out=12, result=12, reg_write=1.
REQ-031 STORE rd1=0x100, imm=4, rd2=0xDEADBEEF, then LOAD same address -> result=0xDEADBEEF, result_src path, reg_write=1 on load only.
REQ-032 BEQ rd1=rd2=3 -> eq=1, pc_src=01; BEQ rd1=3, rd2=4 -> pc_src=00; BNE inverse.
REQ-033 JALR rd1=0x200, imm=8 -> result=0x208, pc_src=10, wd3_src=1.
REQ-034 EXIT then STORE -> halted=1 next cycle, memory word unchanged, reg_write=0; rst=0 one cycle -> halted=0.
REQ-035 SRA operand1=0x80000000, imm=4 -> 0xF8000000; SLTU 1 vs 0xFFFFFFFF -> 1; opcode 0x20 -> all controls 0.
